// File: rtl/button_debouncer_pkg.sv
// Shared state encoding for the button debouncer. The state decode is also used
// by the LED display logic.
package button_debouncer_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // The debounced level holds through the release qualification window.
  function automatic logic level_of(input state_t st);
    return (st == PRESSED) || (st == RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous single-bit inputs. Both flops are
// cleared by a synchronous active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of the flop that feeds it.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: a 2-flop synchroniser feeding a tick-qualified FSM,
// with registered press/release strobes. The optional auto-repeat is enabled by
// defining BUTTON_DEBOUNCER_AUTOREPEAT_EN.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int STABLE_TICKS  = 4,
  parameter int CNT_W         = 8,
  parameter int REPEAT_DELAY  = 32,
  parameter int REPEAT_PERIOD = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               btn_raw,
  output logic               btn_level,
  output logic               press_pulse,
  output logic               release_pulse,
  output logic [STATE_W-1:0] state
);

  if (STABLE_TICKS < 1 || STABLE_TICKS > (1 << CNT_W) ||
      REPEAT_DELAY < 1 || REPEAT_DELAY > (1 << CNT_W) ||
      REPEAT_PERIOD < 1 || REPEAT_PERIOD > (1 << CNT_W)) begin : g_bad_params
    $error("button_debouncer: tick count parameter out of range");
  end

  localparam logic [CNT_W-1:0] STABLE_TERM = CNT_W'(STABLE_TICKS - 1);

  logic             s;
  state_t           cur_state, nxt_state;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             press_nxt, release_nxt;
  logic             rpt_hit;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_raw),
    .q   (s)
  );

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_TERM  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_TERM = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] rpt_cnt;
  logic             rpt_armed;

  // The first repeat waits the long delay; later ones use the shorter period.
  assign rpt_hit = (cur_state == PRESSED) && s && tick &&
                   (rpt_cnt == (rpt_armed ? PERIOD_TERM : DELAY_TERM));

  always_ff @(posedge clk) begin
    if (rst || cur_state != PRESSED || !s) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
    end else if (tick) begin
      if (rpt_hit) begin
        rpt_cnt   <= '0;
        rpt_armed <= 1'b1;
      end else begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end
    end
  end
`else
  assign rpt_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state     <= IDLE;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      cur_state     <= nxt_state;
      cnt           <= cnt_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    nxt_state   = cur_state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    unique case (cur_state)
      IDLE: begin
        if (s) begin
          nxt_state = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        // A falling input wins over a coincident tick: that is bounce rejection.
        if (!s) begin
          nxt_state = IDLE;
        end else if (tick) begin
          if (cnt == STABLE_TERM) begin
            nxt_state = PRESSED;
            press_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      PRESSED: begin
        if (!s) begin
          nxt_state = RELEASE_WAIT;
          cnt_nxt   = '0;
        end else if (rpt_hit) begin
          press_nxt = 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          nxt_state = PRESSED;
        end else if (tick) begin
          if (cnt == STABLE_TERM) begin
            nxt_state   = IDLE;
            release_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  assign btn_level = level_of(cur_state);
  assign state     = cur_state;

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: a directed vector table, hand-written
// corner sequences, and randomized stimulus against a level/pending-tick model.
module tb_button_debouncer;

  localparam int ST = 4;
  localparam int CW = 8;
  localparam int RD = 32;
  localparam int RP = 8;

  logic       clk, rst, tick, btn_raw;
  logic       btn_level, press_pulse, release_pulse;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  button_debouncer #(
    .STABLE_TICKS  (ST),
    .CNT_W         (CW),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tick          (tick),
    .btn_raw       (btn_raw),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .state         (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a debounced level plus a "pending disagreement" flag with
  // the number of ticks the disagreement has survived. The raw input reaches it
  // through a two-sample delay line.
  logic m_s1, m_s2, m_level, m_pend, m_press, m_rel;
  int   m_ticks, m_held;

  function automatic logic [1:0] m_state();
    if (!m_level) return m_pend ? 2'd1 : 2'd0;
    else          return m_pend ? 2'd3 : 2'd2;
  endfunction

  task automatic model_edge(input logic r, input logic b, input logic t);
    logic s, stable_high;
    if (r) begin
      {m_s1, m_s2, m_level, m_pend, m_press, m_rel} = '0;
      m_ticks = 0;
      m_held  = 0;
      return;
    end
    s           = m_s2;
    stable_high = m_level && !m_pend;
    m_press     = 1'b0;
    m_rel       = 1'b0;
    if (!m_pend) begin
      if (s != m_level) begin
        m_pend  = 1'b1;
        m_ticks = 0;
      end
    end else if (s == m_level) begin
      m_pend = 1'b0;
    end else if (t) begin
      m_ticks++;
      if (m_ticks == ST) begin
        m_level = ~m_level;
        m_pend  = 1'b0;
        if (m_level) m_press = 1'b1;
        else         m_rel   = 1'b1;
      end
    end
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
    if (stable_high && s) begin
      if (t) begin
        m_held++;
        if (m_held >= RD && (m_held - RD) % RP == 0) m_press = 1'b1;
      end
    end else begin
      m_held = 0;
    end
`else
    if (stable_high && s && t) m_held++;
    else if (!(stable_high && s)) m_held = 0;
`endif
    m_s2 = m_s1;
    m_s1 = b;
  endtask

  // Drive inputs, clock once, advance the model, compare on the falling edge.
  task automatic step(input logic r, input logic b, input logic t);
    rst     = r;
    btn_raw = b;
    tick    = t;
    @(posedge clk);
    model_edge(r, b, t);
    @(negedge clk);
    check("model_state",   32'(state),         32'(m_state()));
    check("model_level",   32'(btn_level),     32'(m_level));
    check("model_press",   32'(press_pulse),   32'(m_press));
    check("model_release", 32'(release_pulse), 32'(m_rel));
  endtask

  typedef struct packed {
    logic       r, b, t;
    logic [1:0] st;
    logic       lv, pp, rp;
  } vec_t;

  function automatic vec_t v(input logic r, input logic b, input logic t,
                             input logic [1:0] st, input logic lv,
                             input logic pp, input logic rp);
    return '{r: r, b: b, t: t, st: st, lv: lv, pp: pp, rp: rp};
  endfunction

  vec_t vecs[33];

  initial begin
    int pcount, rcount, bad, saw_pw, press_idx, level_idx, budget;
    logic hold_b;
    int hold_left;

    // Reset, clean press, release bounce, clean release, then the
    // fall-with-4th-tick priority case.
    vecs[0]  = v(1, 0, 0, 0, 0, 0, 0);
    vecs[1]  = v(0, 1, 0, 0, 0, 0, 0);
    vecs[2]  = v(0, 1, 1, 0, 0, 0, 0);
    vecs[3]  = v(0, 1, 1, 1, 0, 0, 0);
    vecs[4]  = v(0, 1, 1, 1, 0, 0, 0);
    vecs[5]  = v(0, 1, 0, 1, 0, 0, 0);
    vecs[6]  = v(0, 1, 1, 1, 0, 0, 0);
    vecs[7]  = v(0, 1, 1, 1, 0, 0, 0);
    vecs[8]  = v(0, 1, 1, 2, 1, 1, 0);
    vecs[9]  = v(0, 1, 0, 2, 1, 0, 0);
    vecs[10] = v(0, 0, 0, 2, 1, 0, 0);
    vecs[11] = v(0, 0, 1, 2, 1, 0, 0);
    vecs[12] = v(0, 0, 1, 3, 1, 0, 0);
    vecs[13] = v(0, 1, 1, 3, 1, 0, 0);
    vecs[14] = v(0, 1, 0, 3, 1, 0, 0);
    vecs[15] = v(0, 1, 0, 2, 1, 0, 0);
    vecs[16] = v(0, 0, 0, 2, 1, 0, 0);
    vecs[17] = v(0, 0, 0, 2, 1, 0, 0);
    vecs[18] = v(0, 0, 0, 3, 1, 0, 0);
    vecs[19] = v(0, 0, 1, 3, 1, 0, 0);
    vecs[20] = v(0, 0, 1, 3, 1, 0, 0);
    vecs[21] = v(0, 0, 1, 3, 1, 0, 0);
    vecs[22] = v(0, 0, 1, 0, 0, 0, 1);
    vecs[23] = v(0, 0, 0, 0, 0, 0, 0);
    vecs[24] = v(0, 1, 0, 0, 0, 0, 0);
    vecs[25] = v(0, 1, 0, 0, 0, 0, 0);
    vecs[26] = v(0, 1, 0, 1, 0, 0, 0);
    vecs[27] = v(0, 1, 1, 1, 0, 0, 0);
    vecs[28] = v(0, 1, 1, 1, 0, 0, 0);
    vecs[29] = v(0, 0, 1, 1, 0, 0, 0);
    vecs[30] = v(0, 0, 0, 1, 0, 0, 0);
    vecs[31] = v(0, 0, 1, 0, 0, 0, 0);
    vecs[32] = v(0, 0, 0, 0, 0, 0, 0);

    rst = 1'b1; btn_raw = 1'b0; tick = 1'b0;
    step(1, 0, 0);
    check("reset_state", 32'(state), 32'd0);
    check("reset_level", 32'(btn_level), 32'd0);
    check("reset_press", 32'(press_pulse), 32'd0);
    check("reset_release", 32'(release_pulse), 32'd0);

    for (int i = 0; i < 33; i++) begin
      step(vecs[i].r, vecs[i].b, vecs[i].t);
      check($sformatf("vec%0d_state", i),   32'(state),         32'(vecs[i].st));
      check($sformatf("vec%0d_level", i),   32'(btn_level),     32'(vecs[i].lv));
      check($sformatf("vec%0d_press", i),   32'(press_pulse),   32'(vecs[i].pp));
      check($sformatf("vec%0d_release", i), 32'(release_pulse), 32'(vecs[i].rp));
    end

    // Bounce: high for one tick period then low, five times, tick every 10 clk.
    bad = 0; saw_pw = 0;
    for (int rep = 0; rep < 5; rep++) begin
      for (int c = 0; c < 20; c++) begin
        step(0, (c < 10), (c % 10 == 9));
        if (state > 2'd1 || press_pulse || btn_level) bad++;
        if (state == 2'd1) saw_pw = 1;
      end
    end
    check("bounce_violations", 32'(bad), 32'd0);
    check("bounce_reached_press_wait", 32'(saw_pw), 32'd1);

    // Clean press: held high 100 clk with a tick every 10 clk.
    pcount = 0; press_idx = -1; level_idx = -1;
    for (int c = 0; c < 100; c++) begin
      step(0, 1, (c % 10 == 9));
      if (press_pulse) begin
        pcount++;
        if (press_idx < 0) press_idx = c;
      end
      if (btn_level && level_idx < 0) level_idx = c;
    end
    check("clean_press_count", 32'(pcount), 32'd1);
    check("clean_press_cycle", 32'(press_idx), 32'd39);
    check("clean_level_cycle", 32'(level_idx), 32'd39);

    // Clean release.
    rcount = 0;
    for (int c = 0; c < 60; c++) begin
      step(0, 0, (c % 10 == 9));
      if (release_pulse) rcount++;
    end
    check("clean_release_count", 32'(rcount), 32'd1);
    check("clean_release_level", 32'(btn_level), 32'd0);

    // Reset while PRESSED aborts to IDLE with no pulses afterwards.
    for (int c = 0; c < 10; c++) step(0, 1, 1);
    check("pre_reset_state", 32'(state), 32'd2);
    step(1, 0, 0);
    check("midreset_state", 32'(state), 32'd0);
    check("midreset_outputs", 32'({btn_level, press_pulse, release_pulse}), 32'd0);
    rcount = 0; bad = 0;
    for (int c = 0; c < 20; c++) begin
      step(0, 0, 1);
      if (release_pulse) rcount++;
      if (state != 2'd0) bad++;
    end
    check("post_reset_release", 32'(rcount), 32'd0);
    check("post_reset_idle", 32'(bad), 32'd0);

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
    // Held for 60 ticks in PRESSED: initial press plus repeats at 32, 40, 48, 56.
    pcount = 0; budget = 0;
    while (state != 2'd2 && budget < 50) begin
      step(0, 1, 1);
      if (press_pulse) pcount++;
      budget++;
    end
    check("repeat_reached_pressed", 32'(state), 32'd2);
    for (int c = 0; c < 122; c++) begin
      step(0, 1, (c < 120) && (c % 2 == 0));
      if (press_pulse) pcount++;
    end
    check("repeat_press_count", 32'(pcount), 32'd5);
    for (int c = 0; c < 40; c++) step(0, 0, 1);
`endif

    // Randomized stimulus against the model.
    hold_b = 1'b0; hold_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold_left == 0) begin
        hold_b    = ~hold_b;
        hold_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(40, 200))
                                                : int'($urandom_range(1, 12));
      end
      hold_left--;
      step(($urandom_range(0, 799) == 0), hold_b, ($urandom_range(0, 2) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
